// File: rtl/reg_ctrl_pkg.sv
// rtl/reg_ctrl_pkg.sv - shared opcodes, FSM encoding and width default for reg_access_ctrl
package reg_ctrl_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational ALU computing d <- d op s with carry/borrow
module alu8
    import reg_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] s_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] wide;

    // The extra top bit of the widened sum/difference is carry for ADD and borrow (d<s) for SUB/CMP.
    always_comb begin
        wide     = '0;
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                wide     = {1'b0, d_i} + {1'b0, s_i};
                result_o = wide[DATA_W-1:0];
                carry_o  = wide[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                wide     = {1'b0, d_i} - {1'b0, s_i};
                result_o = wide[DATA_W-1:0];
                carry_o  = wide[DATA_W];
            end
            OP_AND:  result_o = d_i & s_i;
            OP_OR:   result_o = d_i | s_i;
            OP_MOV:  result_o = s_i;
            OP_LDI:  result_o = imm_i;
            OP_NOT:  result_o = ~s_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - read/execute/write sequencer driving the 4-entry register group
module reg_access_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [2:0]        ins_op,
    input  logic [1:0]        ins_sr,
    input  logic [1:0]        ins_dr,
    input  logic [DATA_W-1:0] ins_imm,
    output logic [1:0]        rf_sr,
    output logic [1:0]        rf_dr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_i,
    input  logic [DATA_W-1:0] rf_s,
    input  logic [DATA_W-1:0] rf_d,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z
);

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [1:0]          sr_q, sr_d;
    logic [1:0]          dr_q, dr_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   s_q, s_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                flag_c_q, flag_c_d;
    logic                flag_z_q, flag_z_d;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;

    alu8 #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op_q),
        .s_i      (s_q),
        .d_i      (d_q),
        .imm_i    (imm_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sr_q     <= '0;
            dr_q     <= '0;
            imm_q    <= '0;
            s_q      <= '0;
            d_q      <= '0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sr_q     <= sr_d;
            dr_q     <= dr_d;
            imm_q    <= imm_d;
            s_q      <= s_d;
            d_q      <= d_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sr_d     = sr_q;
        dr_d     = dr_q;
        imm_d    = imm_q;
        s_d      = s_q;
        d_d      = d_q;
        result_d = result_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        case (state_q)
            ST_IDLE: begin
                if (ins_valid) begin
                    op_d    = ins_op;
                    sr_d    = ins_sr;
                    dr_d    = ins_dr;
                    imm_d   = ins_imm;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                s_d     = rf_s;
                d_d     = rf_d;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                flag_c_d = alu_carry;
                flag_z_d = (alu_result == '0);
                state_d  = (op_q == OP_CMP) ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so reset removes rf_we without waiting for a clock.
    assign ins_ready = (state_q == ST_IDLE);
    assign rf_sr     = (state_q == ST_IDLE) ? 2'd0 : sr_q;
    assign rf_dr     = (state_q == ST_IDLE) ? 2'd0 : dr_q;
    assign rf_we     = (state_q == ST_WRITE);
    assign rf_i      = (state_q == ST_WRITE) ? result_q : '0;
    assign done      = (state_q == ST_WRITE) || ((state_q == ST_EXEC) && (op_q == OP_CMP));
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - directed bench with register-group responder and timeline model
module tb_reg_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ins_valid;
    logic       ins_ready;
    logic [2:0] ins_op;
    logic [1:0] ins_sr, ins_dr;
    logic [7:0] ins_imm;
    logic [1:0] rf_sr, rf_dr;
    logic       rf_we;
    logic [7:0] rf_i, rf_s, rf_d;
    logic       done;
    logic [7:0] result;
    logic       flag_c, flag_z;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reg_access_ctrl #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_op(ins_op), .ins_sr(ins_sr), .ins_dr(ins_dr), .ins_imm(ins_imm),
        .rf_sr(rf_sr), .rf_dr(rf_dr), .rf_we(rf_we), .rf_i(rf_i),
        .rf_s(rf_s), .rf_d(rf_d),
        .done(done), .result(result), .flag_c(flag_c), .flag_z(flag_z)
    );

    // Register group responder: combinational reads, write sampled on the falling edge.
    logic [7:0] rg [4];
    assign rf_s = rg[rf_sr];
    assign rf_d = rg[rf_dr];
    always @(negedge clk) if (rf_we) rg[rf_dr] <= rf_i;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: cycle index since acceptance (0 = idle), architectural registers, held outputs.
    int m_cyc = 0;
    int m_op = 0, m_sr = 0, m_dr = 0, m_imm = 0;
    int m_res = 0, m_c = 0, m_z = 0;
    int mregs [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_res = 0; m_c = 0; m_z = 0;
        end else begin
            case (m_cyc)
                0: if (ins_valid === 1'b1) begin
                    m_op = ins_op; m_sr = ins_sr; m_dr = ins_dr; m_imm = ins_imm;
                    m_cyc = 1;
                end
                1: m_cyc = 2;
                2: begin
                    int d, s, r;
                    d = mregs[m_dr]; s = mregs[m_sr]; r = 0; m_c = 0;
                    case (m_op)
                        0: begin r = d + s; m_c = (r > 255); end
                        1, 7: begin r = d - s; m_c = (d < s); end
                        2: r = d & s;
                        3: r = d | s;
                        4: r = s;
                        5: r = m_imm;
                        default: r = ~s;
                    endcase
                    m_res = r & 255;
                    m_z = (m_res == 0);
                    m_cyc = (m_op == 7) ? 0 : 3;
                end
                default: begin mregs[m_dr] = m_res; m_cyc = 0; end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        chk("ins_ready", ins_ready, m_cyc == 0);
        chk("rf_we", rf_we, m_cyc == 3);
        chk("done", done, (m_cyc == 3) || (m_cyc == 2 && m_op == 7));
        chk("rf_sr", rf_sr, (m_cyc != 0) ? m_sr : 0);
        chk("rf_dr", rf_dr, (m_cyc != 0) ? m_dr : 0);
        chk("rf_i", rf_i, (m_cyc == 3) ? m_res : 0);
        chk("result", result, m_res);
        chk("flag_c", flag_c, m_c);
        chk("flag_z", flag_z, m_z);
        for (int k = 0; k < 4; k++) chk("regfile", rg[k], mregs[k]);
    end

    task automatic wait_ready();
        int n = 0;
        while (ins_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("ready_timeout", 0, 1);
    endtask

    // Issue one instruction; lat = cycle number in which ready returns, we_cnt = cycles with rf_we.
    task automatic run_ins(input int op, input int sr, input int dr, input int imm,
                           output int lat, output int we_cnt);
        @(negedge clk);
        wait_ready();
        ins_valid = 1'b1; ins_op = op; ins_sr = sr; ins_dr = dr; ins_imm = imm;
        @(posedge clk); #1;
        ins_valid = 1'b0; ins_op = ~ins_op; ins_sr = ~ins_sr; ins_dr = ~ins_dr; ins_imm = ~ins_imm;
        lat = 1; we_cnt = 0;
        forever begin
            @(negedge clk);
            if (rf_we) we_cnt++;
            if (ins_ready) break;
            lat++;
            if (lat > 20) begin chk("done_timeout", 0, 1); break; end
        end
    endtask

    initial begin
        int lat, wec, lowcnt;
        rst = 1'b1;
        ins_valid = 1'b0; ins_op = 0; ins_sr = 0; ins_dr = 0; ins_imm = 0;
        rg[0] = 8'd1; rg[1] = 8'd0; rg[2] = 8'd0; rg[3] = 8'd7;
        mregs[0] = 1; mregs[1] = 0; mregs[2] = 0; mregs[3] = 7;
        repeat (3) @(negedge clk);
        chk("rst_ready", ins_ready, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_c, flag_z}, 0);
        rst = 1'b0;

        run_ins(7, 3, 0, 0, lat, wec);
        chk("cmp_latency", lat, 3);
        chk("cmp_we_count", wec, 0);
        chk("cmp_result", result, 8'hFA);
        chk("cmp_c", flag_c, 1);
        chk("cmp_z", flag_z, 0);

        // MOV sr=3 dr=2, then NOT sr=2 dr=1 with ins_valid held across.
        @(negedge clk);
        wait_ready();
        ins_valid = 1'b1; ins_op = 3'b100; ins_sr = 2'd3; ins_dr = 2'd2;
        @(posedge clk); #1;
        ins_op = 3'b110; ins_sr = 2'd2; ins_dr = 2'd1;
        lowcnt = 0;
        @(negedge clk);
        while (!ins_ready && lowcnt < 20) begin lowcnt++; @(negedge clk); end
        chk("b2b_ready_low_cycles", lowcnt, 3);
        @(posedge clk); #1;
        ins_valid = 1'b0;
        @(negedge clk);
        wait_ready();
        chk("mov_r2", rg[2], 8'h07);
        chk("not_r1", rg[1], 8'hF8);

        run_ins(0, 0, 3, 0, lat, wec);
        chk("add_latency", lat, 4);
        chk("add_we_count", wec, 1);
        chk("add_result", result, 8'h08);
        chk("add_r3", rg[3], 8'h08);
        chk("add_flags", {flag_c, flag_z}, 0);

        // Reset in EXEC of ADD sr=0 dr=3: the pending write of 9 must never happen.
        @(negedge clk);
        wait_ready();
        ins_valid = 1'b1; ins_op = 3'b000; ins_sr = 2'd0; ins_dr = 2'd3;
        @(posedge clk); #1;
        ins_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_exec_we", rf_we, 0);
        chk("rst_exec_ready", ins_ready, 1);
        chk("rst_exec_done", done, 0);
        wec = 0;
        repeat (2) begin @(negedge clk); if (rf_we) wec++; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (rf_we) wec++; end
        chk("rst_exec_we_count", wec, 0);
        chk("rst_exec_r3", rg[3], 8'h08);

        run_ins(5, 0, 1, 8'hFF, lat, wec);
        chk("ldi_r1", rg[1], 8'hFF);
        run_ins(0, 1, 0, 0, lat, wec);
        chk("add_wrap_result", result, 8'h00);
        chk("add_wrap_c", flag_c, 1);
        chk("add_wrap_z", flag_z, 1);
        chk("add_wrap_r0", rg[0], 8'h00);

        run_ins(1, 2, 3, 0, lat, wec);
        chk("sub_r3", rg[3], 8'h01);
        chk("sub_c", flag_c, 0);
        run_ins(3, 3, 0, 0, lat, wec);
        chk("or_r0", rg[0], 8'h01);
        run_ins(2, 1, 2, 0, lat, wec);
        chk("and_r2", rg[2], 8'h07);
        run_ins(7, 0, 0, 0, lat, wec);
        chk("cmp_same_z", flag_z, 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
